score_bcd_reader: RTL and testbench
===================================

SCORE_BCD_READER -- requirements
Module: score_bcd_reader

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port points_calculated, input, 1 bit: single-cycle pulse from the score producer meaning points is valid.
REQ-004 SHALL have port points, input, 14 bits: binary score, sampled only on an accepted points_calculated.
REQ-005 SHALL have port num_of_cards, input, `CARD_MAX_NUM_SIZE bits: selects the difficulty, sampled together with points.
REQ-006 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port score_valid, output, 1 bit: one-cycle pulse meaning score_bcd has been updated.
REQ-008 SHALL have port score_bcd, output, 16 bits: four BCD digits, most significant digit in [15:12].
REQ-009 SHALL have port best_bcd, output, 16 bits: best score for the difficulty of the last conversion (HIGH_SCORE_EN only; otherwise tied to 0).
REQ-010 SHALL have port new_record, output, 1 bit: the last conversion set a new best (HIGH_SCORE_EN only; otherwise tied to 0).

Function
REQ-011 SHALL implement the states IDLE, CONVERT and DONE.
REQ-012 In IDLE, a clock edge with points_calculated=1 SHALL capture min(points, 9999) into a 14-bit shift register, latch the difficulty, clear a 4-bit iteration counter, and go to CONVERT.
REQ-013 CONVERT SHALL run double-dabble: each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by 1.
REQ-014 CONVERT SHALL exit to DONE after exactly 14 iterations.
REQ-015 DONE SHALL register score_bcd, pulse score_valid for 1 cycle, and return to IDLE on the same edge.
REQ-016 Latency SHALL be fixed: score_valid is high in the 15th cycle after the capture edge.
REQ-017 busy SHALL be 1 in CONVERT and DONE and 0 in IDLE.
REQ-018 points_calculated SHALL be ignored while busy=1; no queueing.
REQ-019 score_bcd SHALL hold its value until the next DONE.
REQ-020 A num_of_cards value other than `CARD_NUM_EASY, `CARD_NUM_NORMAL or `CARD_NUM_HARD SHALL still be converted but SHALL NOT touch best-score state.
REQ-021 The 9999 saturation SHALL apply before conversion; values 10000..16383 yield 16'h9999.

Reset
REQ-022 rst SHALL force state IDLE, busy=0, score_valid=0, score_bcd=0, best_bcd=0, new_record=0, all three stored best scores=0, and the counter=0.
REQ-023 rst asserted mid-conversion SHALL abort the conversion with no score_valid pulse.
REQ-024 A points_calculated pulse coincident with rst SHALL be dropped.

Configuration
REQ-025 Macro HIGH_SCORE_EN SHALL, when defined, add three 16-bit BCD best registers, one each for easy, normal and hard.
REQ-026 With HIGH_SCORE_EN defined, DONE SHALL compare the new BCD against the stored best as unsigned 16-bit values (valid for packed BCD).
REQ-027 With HIGH_SCORE_EN defined, a strictly greater result SHALL update the stored best and set new_record=1; otherwise the best is unchanged and new_record=0.
REQ-028 With HIGH_SCORE_EN defined, best_bcd SHALL show the post-update best for the latched difficulty; best_bcd and new_record hold until the next DONE.
REQ-029 Without HIGH_SCORE_EN, the best registers and comparator SHALL NOT exist, and best_bcd and new_record SHALL be constant 0.

Verification
REQ-030 SHALL cover: rst, then points=9966 with hard and a points_calculated pulse -> busy for 15 cycles; score_valid in the 15th cycle; score_bcd=16'h9966; new_record=1; best_bcd=16'h9966.
REQ-031 SHALL cover: points=12000 -> score_bcd=16'h9999; points=0 -> score_bcd=16'h0000 and new_record=0.
REQ-032 SHALL cover: easy 5000, then easy 4000 -> second result has best_bcd=16'h5000 and new_record=0; then normal 4000 -> best_bcd=16'h4000 and new_record=1.
REQ-033 SHALL cover: second points_calculated 5 cycles after the first -> ignored; exactly one score_valid pulse, carrying the first value.
REQ-034 SHALL cover: rst at cycle 7 of a conversion -> no score_valid pulse; all outputs 0; a new conversion of 1234 after rst -> 16'h1234.
REQ-035 SHALL cover: build without HIGH_SCORE_EN -> best_bcd=0 and new_record=0 always; score_bcd matches the HIGH_SCORE_EN build for identical stimulus.

Source files
------------

// File: rtl/score_bcd_reader.sv
// Converts a saturated 14-bit binary score to four packed BCD digits with double-dabble.
// Defining HIGH_SCORE_EN adds per-difficulty best-score tracking (best_bcd, new_record).

`ifndef CARD_MAX_NUM_SIZE
`define CARD_MAX_NUM_SIZE 5
`endif
`ifndef CARD_NUM_EASY
`define CARD_NUM_EASY 5'd8
`endif
`ifndef CARD_NUM_NORMAL
`define CARD_NUM_NORMAL 5'd12
`endif
`ifndef CARD_NUM_HARD
`define CARD_NUM_HARD 5'd16
`endif

module score_bcd_reader (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          points_calculated,
    input  logic [13:0]                   points,
    input  logic [`CARD_MAX_NUM_SIZE-1:0] num_of_cards,
    output logic                          busy,
    output logic                          score_valid,
    output logic [15:0]                   score_bcd,
    output logic [15:0]                   best_bcd,
    output logic                          new_record
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    localparam logic [3:0]  LAST_ITER = 4'd13;
    localparam logic [13:0] MAX_SCORE = 14'd9999;

    state_t                         state_q, state_d;
    logic [13:0]                    bin_q, bin_d;
    logic [15:0]                    bcd_q, bcd_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [`CARD_MAX_NUM_SIZE-1:0]  diff_q, diff_d;
    logic [15:0]                    score_q, score_d;
    logic [15:0]                    bcd_adj;
    logic [29:0]                    shifted;

    // One double-dabble step; the final result is taken straight from this so it is
    // ready in the DONE cycle rather than one cycle later.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        score_d     = score_q;
        busy        = (state_q != IDLE);
        score_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (points_calculated) begin
                    bin_d   = (points > MAX_SCORE) ? MAX_SCORE : points;
                    bcd_d   = 16'd0;
                    cnt_d   = 4'd0;
                    diff_d  = num_of_cards;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = shifted[29:14];
                bin_d = shifted[13:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    score_d = shifted[29:14];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            score_q <= score_d;
        end
    end

    assign score_bcd = score_q;

`ifdef HIGH_SCORE_EN
    logic [15:0] best_easy_q, best_easy_d;
    logic [15:0] best_normal_q, best_normal_d;
    logic [15:0] best_hard_q, best_hard_d;
    logic [15:0] best_out_q, best_out_d;
    logic        new_record_q, new_record_d;
    logic [15:0] cur_best;
    logic [15:0] final_bcd;
    logic        finalize;
    logic        known;

    // Packed BCD orders the same as its binary value, so a plain unsigned compare works.
    // An unrecognised difficulty reports a best of 0 and never records.
    always_comb begin
        finalize      = (state_q == CONVERT) && (cnt_q == LAST_ITER);
        final_bcd     = shifted[29:14];
        best_easy_d   = best_easy_q;
        best_normal_d = best_normal_q;
        best_hard_d   = best_hard_q;
        best_out_d    = best_out_q;
        new_record_d  = new_record_q;
        known         = 1'b1;
        cur_best      = 16'd0;
        if (diff_q == `CARD_NUM_EASY) begin
            cur_best = best_easy_q;
        end else if (diff_q == `CARD_NUM_NORMAL) begin
            cur_best = best_normal_q;
        end else if (diff_q == `CARD_NUM_HARD) begin
            cur_best = best_hard_q;
        end else begin
            known = 1'b0;
        end
        if (finalize) begin
            new_record_d = 1'b0;
            best_out_d   = cur_best;
            if (known && (final_bcd > cur_best)) begin
                new_record_d = 1'b1;
                best_out_d   = final_bcd;
                if (diff_q == `CARD_NUM_EASY) begin
                    best_easy_d = final_bcd;
                end else if (diff_q == `CARD_NUM_NORMAL) begin
                    best_normal_d = final_bcd;
                end else begin
                    best_hard_d = final_bcd;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_easy_q   <= '0;
            best_normal_q <= '0;
            best_hard_q   <= '0;
            best_out_q    <= '0;
            new_record_q  <= 1'b0;
        end else begin
            best_easy_q   <= best_easy_d;
            best_normal_q <= best_normal_d;
            best_hard_q   <= best_hard_d;
            best_out_q    <= best_out_d;
            new_record_q  <= new_record_d;
        end
    end

    assign best_bcd   = best_out_q;
    assign new_record = new_record_q;
`else
    assign best_bcd   = 16'd0;
    assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_bcd_reader.sv
// Randomized scoreboard bench for score_bcd_reader; the decimal reference model
// follows HIGH_SCORE_EN the same way the design does.
`timescale 1ns/1ps

`ifndef CARD_MAX_NUM_SIZE
`define CARD_MAX_NUM_SIZE 5
`endif
`ifndef CARD_NUM_EASY
`define CARD_NUM_EASY 5'd8
`endif
`ifndef CARD_NUM_NORMAL
`define CARD_NUM_NORMAL 5'd12
`endif
`ifndef CARD_NUM_HARD
`define CARD_NUM_HARD 5'd16
`endif

module tb_score_bcd_reader;

    localparam int W = `CARD_MAX_NUM_SIZE;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         points_calculated = 1'b0;
    logic [13:0]  points = 14'd0;
    logic [W-1:0] num_of_cards = '0;
    logic         busy;
    logic         score_valid;
    logic [15:0]  score_bcd;
    logic [15:0]  best_bcd;
    logic         new_record;

    typedef struct packed {
        logic [15:0] score;
        logic [15:0] best;
        logic        rec;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         held = '0;
    int           tests_run = 0;
    int           tests_failed = 0;
    int           rem = 0;
    int           pend_points = 0;
    logic [W-1:0] pend_cards = '0;
    int           best_model[3] = '{0, 0, 0};
    logic [W-1:0] cards_tab[4];

    always #5 clk = ~clk;

    score_bcd_reader dut (
        .clk               (clk),
        .rst               (rst),
        .points_calculated (points_calculated),
        .points            (points),
        .num_of_cards      (num_of_cards),
        .busy              (busy),
        .score_valid       (score_valid),
        .score_bcd         (score_bcd),
        .best_bcd          (best_bcd),
        .new_record        (new_record)
    );

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int card_index(input logic [W-1:0] c);
        if (c == `CARD_NUM_EASY) return 0;
        if (c == `CARD_NUM_NORMAL) return 1;
        if (c == `CARD_NUM_HARD) return 2;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a conversion finishes 14 edges after capture and is busy for 15 cycles
    task automatic complete_conversion();
        exp_t e;
        int   s;
        int   idx;
        s       = (pend_points > 9999) ? 9999 : pend_points;
        e.score = to_bcd(s);
        e.best  = 16'd0;
        e.rec   = 1'b0;
`ifdef HIGH_SCORE_EN
        idx = card_index(pend_cards);
        if (idx >= 0) begin
            if (s > best_model[idx]) begin
                best_model[idx] = s;
                e.rec = 1'b1;
            end
            e.best = to_bcd(best_model[idx]);
        end
`else
        idx = card_index(pend_cards);
        if (idx > 2) e.rec = 1'b1;
`endif
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            rem = 0;
            exp_q.delete();
            best_model = '{0, 0, 0};
            held = '0;
        end else if (rem == 0) begin
            if (points_calculated) begin
                rem = 15;
                pend_points = int'(points);
                pend_cards = num_of_cards;
            end
        end else begin
            if (rem == 2) complete_conversion();
            rem--;
        end
    end

    // Monitor: pops an expectation whenever the DUT raises score_valid
    always @(posedge clk) begin
        #2;
        checkOutput("busy", {15'd0, busy}, {15'd0, (rem != 0)});
        checkOutput("score_valid", {15'd0, score_valid}, {15'd0, (rem == 1)});
        if (score_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_valid: got score_valid=1, expected no pending result at %0t", $time);
            end else begin
                held = exp_q.pop_front();
            end
        end
        checkOutput("score_bcd", score_bcd, held.score);
        checkOutput("best_bcd", best_bcd, held.best);
        checkOutput("new_record", {15'd0, new_record}, {15'd0, held.rec});
    end

    task automatic applyStimulus(input int p, input logic [W-1:0] c);
        @(negedge clk);
        points = 14'(p);
        num_of_cards = c;
        points_calculated = 1'b1;
        @(negedge clk);
        points_calculated = 1'b0;
        points = 14'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (rem != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rem != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle_timeout: got still busy after %0d cycles, expected idle", n);
        end
        @(negedge clk);
    endtask

    initial begin
        cards_tab[0] = `CARD_NUM_EASY;
        cards_tab[1] = `CARD_NUM_NORMAL;
        cards_tab[2] = `CARD_NUM_HARD;
        cards_tab[3] = W'(3);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(9966, `CARD_NUM_HARD);
        waitIdle();
        applyStimulus(12000, `CARD_NUM_HARD);
        waitIdle();
        applyStimulus(0, `CARD_NUM_HARD);
        waitIdle();

        applyStimulus(5000, `CARD_NUM_EASY);
        waitIdle();
        applyStimulus(4000, `CARD_NUM_EASY);
        waitIdle();
        applyStimulus(4000, `CARD_NUM_NORMAL);
        waitIdle();

        // Second pulse lands while busy and must vanish
        applyStimulus(321, `CARD_NUM_NORMAL);
        repeat (3) @(negedge clk);
        applyStimulus(777, `CARD_NUM_EASY);
        waitIdle();

        // Abort in cycle 7 of a conversion
        applyStimulus(4321, `CARD_NUM_HARD);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(1234, `CARD_NUM_EASY);
        waitIdle();

        // Pulse coincident with reset is dropped
        @(negedge clk);
        rst = 1'b1;
        points = 14'd55;
        points_calculated = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        points_calculated = 1'b0;
        repeat (4) @(negedge clk);

        applyStimulus(8888, W'(3));
        waitIdle();
        applyStimulus(16383, `CARD_NUM_NORMAL);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 16383)), cards_tab[$urandom_range(0, 3)]);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        waitIdle();
        repeat (3) @(negedge clk);

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL leftover_results: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
